// File: rtl/pattern_pkg.sv
// Shared definitions for the serial pattern front end, the 1101 recognizers
// and their benches.
package pattern_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam logic [3:0] PATTERN_1101 = 4'b1101;

  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } ser_state_t;

endpackage

// File: rtl/pattern_stream_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and
// shifts one bit per clock onto a recognizer's serial input. A one-word
// holding buffer lets back-to-back words stream with no gap bits.
module pattern_stream_serializer
  import pattern_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             abort,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       r_state,    w_state;
  logic [WIDTH-1:0] r_shreg,    w_shreg;
  logic [CNT_W-1:0] r_cnt,      w_cnt;
  logic [WIDTH-1:0] r_buf,      w_buf;
  logic             r_buf_full, w_buf_full;

  logic w_xfer;
  logic w_last;

  // Move the word one place toward the serial output end.
  function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
    if (MSB_FIRST)
      return {v[WIDTH-2:0], 1'b0};
    else
      return {1'b0, v[WIDTH-1:1]};
  endfunction

  // A word is taken only when the buffer is free; abort discards it.
  assign w_xfer = din_valid & ~r_buf_full & ~abort;
  assign w_last = (r_cnt == CNT_LAST);

  // Next-state and next-datapath logic; abort overrides everything but reset.
  always_comb begin
    w_state    = r_state;
    w_shreg    = r_shreg;
    w_cnt      = r_cnt;
    w_buf      = r_buf;
    w_buf_full = r_buf_full;
    if (abort) begin
      w_state    = S_IDLE;
      w_buf_full = 1'b0;
      w_cnt      = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            w_shreg = din;
            w_cnt   = '0;
            w_state = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!w_last) begin
            w_shreg = shift_toward_out(r_shreg);
            w_cnt   = r_cnt + 1'b1;
            if (w_xfer) begin
              w_buf      = din;
              w_buf_full = 1'b1;
            end
          end else if (r_buf_full) begin
            // Buffered word follows immediately; din_ready is low here.
            w_shreg    = r_buf;
            w_buf_full = 1'b0;
            w_cnt      = '0;
          end else if (w_xfer) begin
            w_shreg = din;
            w_cnt   = '0;
          end else begin
            w_state = S_IDLE;
            w_cnt   = '0;
          end
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_cnt      <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_shreg    <= w_shreg;
      r_cnt      <= w_cnt;
      r_buf      <= w_buf;
      r_buf_full <= w_buf_full;
    end
  end

  assign bit_valid = (r_state == S_SHIFT);
  assign bit_out   = bit_valid ? (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]) : IDLE_BIT;
  assign word_done = bit_valid & w_last & ~abort;
  assign din_ready = ~r_buf_full;
  assign busy      = bit_valid | r_buf_full;

endmodule

// File: tb/tb_pattern_stream_serializer.sv
// Bench for pattern_stream_serializer: directed scenarios plus a random
// stream, checked cycle by cycle against a bit-queue reference model.
module tb_pattern_stream_serializer;
  import pattern_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       abort = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready, bit_out, bit_valid, word_done, busy;

  logic       l_abort = 1'b0;
  logic [7:0] l_din = 8'h00;
  logic       l_valid = 1'b0;
  logic       l_ready, l_bit, l_bvalid, l_done, l_busy;

  int ntot = 0;
  int npass = 0;
  int cyc = 0;

  // Reference model: bits still to appear for the current word (front is on
  // the output now), plus the one-word holding buffer.
  logic       m_bits[$];
  logic       m_bufv = 1'b0;
  logic [7:0] m_buf = 8'h00;

  always #5 clk = ~clk;

  pattern_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .abort(abort), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .bit_out(bit_out), .bit_valid(bit_valid),
    .word_done(word_done), .busy(busy)
  );

  pattern_stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .abort(l_abort), .din(l_din), .din_valid(l_valid),
    .din_ready(l_ready), .bit_out(l_bit), .bit_valid(l_bvalid),
    .word_done(l_done), .busy(l_busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
  endtask

  task automatic load_word(input logic [7:0] d);
    m_bits.delete();
    for (int i = 0; i < 8; i++) m_bits.push_back(d[7-i]);
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (m_bits.size() > 0);
    chk("bit_valid", bit_valid, ev);
    chk("bit_out",   bit_out,   ev ? m_bits[0] : IDLE_BIT_DEFAULT);
    chk("word_done", word_done, (m_bits.size() == 1) && !abort);
    chk("din_ready", din_ready, !m_bufv);
    chk("busy",      busy,      ev || m_bufv);
  endtask

  task automatic model_edge();
    logic xfer;
    xfer = din_valid && !m_bufv && !abort;
    if (abort) begin
      m_bits.delete();
      m_bufv = 1'b0;
    end else if (m_bits.size() == 0) begin
      if (xfer) load_word(din);
    end else if (m_bits.size() > 1) begin
      void'(m_bits.pop_front());
      if (xfer) begin
        m_buf  = din;
        m_bufv = 1'b1;
      end
    end else begin
      if (m_bufv) begin
        load_word(m_buf);
        m_bufv = 1'b0;
      end else if (xfer) begin
        load_word(din);
      end else begin
        m_bits.delete();
      end
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance model at the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic ab);
    din_valid = v;
    din       = d;
    abort     = ab;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
  endtask

  initial begin
    logic [7:0] lsb_exp;

    // Reset with din_valid held high: reset values, nothing accepted.
    din_valid = 1'b1;
    din       = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    din_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) cycle(1'b0, 8'h00, 1'b0);

    // Single word 8'hD0.
    cyc = 0;
    cycle(1'b1, 8'hD0, 1'b0);
    repeat (9) cycle(1'b0, 8'h00, 1'b0);

    // Back-to-back words through the holding buffer.
    cyc = 0;
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    repeat (16) cycle(1'b0, 8'h00, 1'b0);

    // Abort in cycle 3 with the buffer full.
    cyc = 0;
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h44, 1'b1);
    repeat (6) cycle(1'b0, 8'h00, 1'b0);

    // Asynchronous reset pulse in the middle of cycle 5 of a word.
    cyc = 0;
    cycle(1'b1, 8'h5A, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    m_bits.delete();
    m_bufv = 1'b0;
    check_outputs();
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc = 0;
    cycle(1'b1, 8'hC3, 1'b0);
    repeat (9) cycle(1'b0, 8'h00, 1'b0);

    // Random stream with occasional aborts.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 39) == 0);
    repeat (20) cycle(1'b0, 8'h00, 1'b0);

    // LSB-first instance: 8'h0B must serialize as 1,1,0,1,0,0,0,0.
    lsb_exp = 8'b1101_0000;
    chk("lsb_din_ready", l_ready, 1'b1);
    l_valid = 1'b1;
    l_din   = 8'h0B;
    cycle(1'b0, 8'h00, 1'b0);
    l_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("lsb_bit_out",   l_bit,    lsb_exp[7-i]);
      chk("lsb_bit_valid", l_bvalid, 1'b1);
      chk("lsb_word_done", l_done,   i == 7);
      cycle(1'b0, 8'h00, 1'b0);
    end
    chk("lsb_bit_valid_end", l_bvalid, 1'b0);
    chk("lsb_busy_end",      l_busy,   1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/pattern_stream_serializer.md
# pattern_stream_serializer

Parallel-to-serial front end for the serial pattern recognizers (Moore/Mealy `1101` detectors). It accepts WIDTH-bit words over a valid/ready handshake and drives one bit per clock onto the recognizer's `string_in`. A one-word holding buffer lets consecutive words stream with no gap bits. Downstream recognizers have no enable input, so whenever no word is being shifted the output holds a fixed idle level.

## Interface
- `WIDTH`, 8, word width in bits, ≥2.
- `MSB_FIRST`, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.
- `IDLE_BIT`, 1'b0, level driven on `bit_out` when not shifting.

- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `abort`  in  1  synchronous clear; drops the current word and the buffered word.
- `din`  in  WIDTH  parallel word.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  buffer can accept; equals `!buf_full`.
- `bit_out`  out  1  serial bit; connects to the recognizer `string_in`.
- `bit_valid`  out  1  `bit_out` carries word data (state SHIFT).
- `word_done`  out  1  one-cycle pulse while the last bit of a word is on `bit_out`.
- `busy`  out  1  SHIFT, or buffer full.

## Operation
- **Registers:** `state` {IDLE, SHIFT}, shift register `shreg[WIDTH-1:0]`, bit counter `cnt[$clog2(WIDTH)-1:0]`, holding register `buf`, flag `buf_full`.
- **Handshake:** transfer occurs when `din_valid & din_ready`. `din_ready = !buf_full`; a word is never accepted on a full buffer, including on the drain cycle.
- **IDLE:**
  - Transfer: `din` loads straight into `shreg`, `cnt` = 0, go to SHIFT.
  - No transfer: stay in IDLE.
- **SHIFT, `cnt` < WIDTH-1:**
  - Shift `shreg` one place toward the output end; `cnt`++.
  - A transfer in this state writes `buf` and sets `buf_full`.
- **SHIFT, `cnt` = WIDTH-1 (last bit):**
  - If `buf_full`: load `buf` into `shreg`, clear `buf_full`, `cnt` = 0, stay in SHIFT.
  - Else if transfer: load `din` into `shreg`, `cnt` = 0, stay in SHIFT.
  - Else: go to IDLE.
- **Outputs:**
  - `bit_out` = `shreg[WIDTH-1]` (MSB_FIRST=1) or `shreg[0]` (MSB_FIRST=0) in SHIFT; `IDLE_BIT` in IDLE.
  - `bit_valid` = (state == SHIFT).
  - `word_done` = SHIFT & (`cnt` == WIDTH-1).
- **`abort`:** highest priority after `reset`. Next state is IDLE, `buf_full` = 0, `cnt` = 0. A transfer in the same cycle is discarded, and `word_done` is suppressed in that cycle.
- **Reset values:** state IDLE, `shreg`/`buf`/`cnt` = 0, `buf_full` = 0, so `bit_out` = `IDLE_BIT`, `bit_valid` = 0, `word_done` = 0, `busy` = 0, `din_ready` = 1. Handshakes while `reset` is high are ignored. Reset mid-word takes effect immediately, with no partial completion.

## Timing
- Latency: word accepted in cycle N from IDLE → first bit on `bit_out` in cycle N+1, last bit in cycle N+WIDTH, `word_done` in cycle N+WIDTH.
- Throughput: one word per WIDTH cycles sustained; `bit_valid` stays continuously high across back-to-back words.
- Buffer timing: a word accepted in SHIFT sets `din_ready` low from the next cycle. `din_ready` returns high the cycle after the last-bit cycle of the word currently being shifted.
- All outputs derive from registers through one mux level only; there is no combinational path from `din`/`din_valid` to any output.

## Structure
- Shared package `pattern_pkg`:
  - state encoding localparams `ST_IDLE` = 1'b0, `ST_SHIFT` = 1'b1;
  - `PATTERN_1101` = 4'b1101;
  - default `IDLE_BIT`.
  - Used by this block, the recognizers, and benches.
- No sub-module. The holding buffer is a single register plus a flag, kept inline.
- Integration top wires `bit_out` → `string_in`, sharing `clk`/`reset` with the recognizer.

## Test plan
Default parameters unless stated; handshake in cycle 0.
1. Reset asserted → `bit_out` = 0, `bit_valid` = 0, `word_done` = 0, `busy` = 0, `din_ready` = 1. `din_valid` = 1 during reset → nothing shifted after release.
2. Word 8'hD0 → `bit_out` 1,1,0,1,0,0,0,0 in cycles 1–8, `bit_valid` high in cycles 1–8, `word_done` in cycle 8, IDLE in cycle 9. With the Mealy recognizer attached, `seen` pulses in cycle 4.
3. 8'hA5 in cycle 0, then 8'h3C in cycle 1 → `buf_full` in cycles 2–8, `din_ready` low in cycles 2–8. Bits 10100101 then 00111100 in cycles 1–16 with no gap; `word_done` in cycles 8 and 16.
4. MSB_FIRST=0, word 8'h0B → `bit_out` 1,1,0,1,0,0,0,0 in cycles 1–8.
5. `abort` in cycle 3 with buffer full → cycle 4: IDLE, `bit_out` = `IDLE_BIT`, `din_ready` = 1, `busy` = 0; no `word_done` in cycles 3–8.
6. Async `reset` pulse mid-cycle in cycle 5 of a word → outputs reach reset values without waiting for a clock edge. A new word after release starts cleanly at bit 0.
